note_player: RTL and testbench
==============================

NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-002 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port play_enable, input, 1 bit: 1 = advance note time and phase, 0 = pause.
REQ-004 The module SHALL have port note_to_load, input, 6 bits: note index; 0 = rest, 1-63 = semitone steps.
REQ-005 The module SHALL have port duration_to_load, input, 6 bits: note length in beats.
REQ-006 The module SHALL have port load_new_note, input, 1 bit: one-cycle strobe that captures note_to_load and duration_to_load.
REQ-007 The module SHALL have port beat, input, 1 bit: one-cycle beat strobe.
REQ-008 The module SHALL have port generate_next_sample, input, 1 bit: one-cycle sample-rate strobe (48 kHz).
REQ-009 The module SHALL have port note_done, output, 1 bit: one-cycle pulse when the loaded duration expires.
REQ-010 The module SHALL have port phase, output, 20 bits: unsigned 10.10 phase accumulator that addresses the downstream sine table.
REQ-011 The module SHALL have port sample_valid, output, 1 bit: one-cycle pulse marking a phase update.
REQ-012 The module SHALL have port playing, output, 1 bit: high while a note is active (state PLAYING or PAUSED).

Function
REQ-013 The module SHALL implement states IDLE, PLAYING and PAUSED.
REQ-014 IDLE SHALL go to PLAYING on load_new_note.
REQ-015 PLAYING SHALL go to PAUSED when play_enable=0.
REQ-016 PAUSED SHALL go to PLAYING when play_enable=1.
REQ-017 PLAYING SHALL go to IDLE when the duration counter expires.
REQ-018 On load_new_note, in any state, the module SHALL register the note, load a 6-bit down-counter with duration_to_load, and clear phase to 0 on the next edge.
REQ-019 In PLAYING, each beat SHALL decrement the counter by 1.
REQ-020 In PLAYING, when a beat arrives with the counter at 1, the module SHALL assert note_done for exactly the next cycle and enter IDLE.
REQ-021 A load with duration 0 SHALL produce note_done on the cycle after the load and return to IDLE, with no phase advance.
REQ-022 Beats in IDLE or PAUSED SHALL be ignored, and the counter SHALL hold.
REQ-023 step_size SHALL be 20 bits, obtained from frequency_rom addressed by the registered note, with 1-cycle synchronous-read latency.
REQ-024 step_size SHALL become valid 2 cycles after load_new_note; a sample strobe before then SHALL add 0.
REQ-025 On generate_next_sample in PLAYING, the module SHALL update phase <= phase + step_size, modulo 2^20 (wrap-around silent, no flag).
REQ-026 sample_valid SHALL pulse in the cycle after the phase update.
REQ-027 In IDLE or PAUSED, phase SHALL hold, and sample_valid SHALL pulse on each strobe with phase unchanged, so the downstream sample rate is never interrupted.
REQ-028 Note 0 (rest) SHALL map to step_size 0: the state machine runs and note_done fires normally, but phase stays 0.
REQ-029 When load_new_note and an expiring beat occur in the same cycle, the load SHALL win: no note_done, the new note starts.
REQ-030 A load while PLAYING or PAUSED SHALL silently replace the current note (no note_done for the old note), and the state SHALL become PLAYING if play_enable=1, else PAUSED.
REQ-031 When a beat and generate_next_sample coincide, both SHALL take effect in the same cycle.

Reset
REQ-032 Reset SHALL force state IDLE, counter 0, registered note 0, phase 0, note_done 0, sample_valid 0 and playing 0.
REQ-033 Reset SHALL take priority over every other input.
REQ-034 A reset mid-note SHALL abort the note with no note_done pulse.

Structure
REQ-035 A shared package SHALL hold the state enum and the following constants:
- NOTE_W=6
- DUR_W=6
- PHASE_W=20
- SAMPLE_RATE=48000
- REST_NOTE=0
REQ-036 A single sub-module, frequency_rom, SHALL hold the 64x20 step table, sync read, where step = round(f_note * 2^20 / 48000), note 49 = A4 = 440 Hz -> 9612, and note 0 -> 0.
REQ-037 The duration counter and the phase accumulator SHALL be the only arithmetic; there SHALL be no multipliers.

Verification
REQ-038 The bench SHALL cover a basic note: load note 49 / duration 3 with play_enable=1, then 3 beats -> note_done pulses once, 1 cycle after the 3rd beat, and playing falls on the same edge.
REQ-039 The bench SHALL cover the phase step: note 49, then 4 sample strobes after the step is valid -> phase = 38448, sample_valid pulses 4 times.
REQ-040 The bench SHALL cover wrap-around: note 63, with strobes applied until phase exceeds 2^20 -> phase = (sum of steps) mod 1048576, and no glitch on note_done.
REQ-041 The bench SHALL cover pause: play_enable=0 for 5 beats mid-note -> counter holds, phase holds, note_done is delayed by exactly those beats.
REQ-042 The bench SHALL cover load plus expiry: load_new_note coincident with the final beat -> no note_done, new duration counted from the load.
REQ-043 The bench SHALL cover reset mid-note: reset asserted at beat 1 of 4 -> all outputs 0 on the next edge, no note_done ever for that note.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player datapath.
package note_player_pkg;

  localparam int unsigned NOTE_W      = 6;
  localparam int unsigned DUR_W       = 6;
  localparam int unsigned PHASE_W     = 20;
  localparam int unsigned SAMPLE_RATE = 48000;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

endpackage

// File: rtl/note_player_frequency_rom.sv
// 64 x 20 phase-step table: step = round(f_note * 2^20 / SAMPLE_RATE),
// equal temperament with note 49 = A4 = 440 Hz; note 0 (rest) steps by 0.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic               clk,
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] step_size
);

  localparam int unsigned A4_STEP = (440 * (1 << PHASE_W) + SAMPLE_RATE / 2) / SAMPLE_RATE;

  logic [PHASE_W-1:0] rom_word;

  // table lookup
  always_comb begin
    rom_word = '0;
    case (note)
      REST_NOTE: rom_word = '0;
      6'd1:  rom_word = 20'd601;
      6'd2:  rom_word = 20'd636;
      6'd3:  rom_word = 20'd674;
      6'd4:  rom_word = 20'd714;
      6'd5:  rom_word = 20'd757;
      6'd6:  rom_word = 20'd802;
      6'd7:  rom_word = 20'd850;
      6'd8:  rom_word = 20'd900;
      6'd9:  rom_word = 20'd954;
      6'd10: rom_word = 20'd1010;
      6'd11: rom_word = 20'd1070;
      6'd12: rom_word = 20'd1134;
      6'd13: rom_word = 20'd1201;
      6'd14: rom_word = 20'd1273;
      6'd15: rom_word = 20'd1349;
      6'd16: rom_word = 20'd1429;
      6'd17: rom_word = 20'd1514;
      6'd18: rom_word = 20'd1604;
      6'd19: rom_word = 20'd1699;
      6'd20: rom_word = 20'd1800;
      6'd21: rom_word = 20'd1907;
      6'd22: rom_word = 20'd2021;
      6'd23: rom_word = 20'd2141;
      6'd24: rom_word = 20'd2268;
      6'd25: rom_word = 20'd2403;
      6'd26: rom_word = 20'd2546;
      6'd27: rom_word = 20'd2697;
      6'd28: rom_word = 20'd2858;
      6'd29: rom_word = 20'd3028;
      6'd30: rom_word = 20'd3208;
      6'd31: rom_word = 20'd3398;
      6'd32: rom_word = 20'd3600;
      6'd33: rom_word = 20'd3815;
      6'd34: rom_word = 20'd4041;
      6'd35: rom_word = 20'd4282;
      6'd36: rom_word = 20'd4536;
      6'd37: rom_word = 20'd4806;
      6'd38: rom_word = 20'd5092;
      6'd39: rom_word = 20'd5395;
      6'd40: rom_word = 20'd5715;
      6'd41: rom_word = 20'd6055;
      6'd42: rom_word = 20'd6415;
      6'd43: rom_word = 20'd6797;
      6'd44: rom_word = 20'd7201;
      6'd45: rom_word = 20'd7629;
      6'd46: rom_word = 20'd8083;
      6'd47: rom_word = 20'd8563;
      6'd48: rom_word = 20'd9072;
      6'd49: rom_word = PHASE_W'(A4_STEP);
      6'd50: rom_word = 20'd10184;
      6'd51: rom_word = 20'd10789;
      6'd52: rom_word = 20'd11431;
      6'd53: rom_word = 20'd12110;
      6'd54: rom_word = 20'd12830;
      6'd55: rom_word = 20'd13593;
      6'd56: rom_word = 20'd14402;
      6'd57: rom_word = 20'd15258;
      6'd58: rom_word = 20'd16165;
      6'd59: rom_word = 20'd17127;
      6'd60: rom_word = 20'd18145;
      6'd61: rom_word = 20'd19224;
      6'd62: rom_word = 20'd20367;
      6'd63: rom_word = 20'd21578;
      default: rom_word = '0;
    endcase
  end

  // synchronous read port
  always_ff @(posedge clk) begin
    step_size <= rom_word;
  end

endmodule

// File: rtl/note_player.sv
// Note sequencer: counts a loaded note's duration in beats and advances a
// 10.10 phase accumulator at the sample rate while the note is playing.
module note_player
  import note_player_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               play_enable,
  input  logic [NOTE_W-1:0]  note_to_load,
  input  logic [DUR_W-1:0]   duration_to_load,
  input  logic               load_new_note,
  input  logic               beat,
  input  logic               generate_next_sample,
  output logic               note_done,
  output logic [PHASE_W-1:0] phase,
  output logic               sample_valid,
  output logic               playing
);

  state_t             state;
  state_t             state_next;
  logic [DUR_W-1:0]   dur_cnt;
  logic [DUR_W-1:0]   dur_cnt_next;
  logic               note_done_next;
  logic [NOTE_W-1:0]  note_reg;
  logic [PHASE_W-1:0] step_size;
  logic               step_ok;

  frequency_rom u_frequency_rom (
    .clk       (clk),
    .note      (note_reg),
    .step_size (step_size)
  );

  assign playing = (state != ST_IDLE);

  // next state, duration counter and expiry pulse; a load overrides everything
  always_comb begin
    state_next     = state;
    dur_cnt_next   = dur_cnt;
    note_done_next = 1'b0;
    if (load_new_note) begin
      dur_cnt_next = duration_to_load;
      if (duration_to_load == '0) begin
        state_next     = ST_IDLE;
        note_done_next = 1'b1;
      end else if (play_enable) begin
        state_next = ST_PLAYING;
      end else begin
        state_next = ST_PAUSED;
      end
    end else begin
      unique case (state)
        ST_PLAYING: begin
          if (beat && ((dur_cnt == DUR_W'(1)) || (dur_cnt == '0))) begin
            dur_cnt_next   = '0;
            state_next     = ST_IDLE;
            note_done_next = 1'b1;
          end else begin
            if (beat) begin
              dur_cnt_next = dur_cnt - DUR_W'(1);
            end
            if (!play_enable) begin
              state_next = ST_PAUSED;
            end
          end
        end
        ST_PAUSED: begin
          if (play_enable) begin
            state_next = ST_PLAYING;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dur_cnt   <= '0;
      note_reg  <= REST_NOTE;
      note_done <= 1'b0;
    end else begin
      state     <= state_next;
      dur_cnt   <= dur_cnt_next;
      note_done <= note_done_next;
      if (load_new_note) begin
        note_reg <= note_to_load;
      end
    end
  end

  // phase accumulator; sample_valid follows every strobe regardless of state.
  // step_ok masks the cycle after a load, when the ROM still shows the old note.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= '0;
      sample_valid <= 1'b0;
      step_ok      <= 1'b0;
    end else begin
      sample_valid <= generate_next_sample;
      step_ok      <= !load_new_note;
      if (load_new_note) begin
        phase <= '0;
      end else if (generate_next_sample && (state == ST_PLAYING) && step_ok) begin
        phase <= phase + step_size;
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: table of notes plus hand-written corner sequences;
// phase values are checked through a scoreboard on every sample_valid pulse.
module tb_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        beat;
  logic        generate_next_sample;
  logic        note_done;
  logic [19:0] phase;
  logic        sample_valid;
  logic        playing;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [19:0] sb_q[$];

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .load_new_note        (load_new_note),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .note_done            (note_done),
    .phase                (phase),
    .sample_valid         (sample_valid),
    .playing              (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; a strobe queues the phase expected with its sample_valid.
  task automatic drive(input logic ld, input logic [5:0] n, input logic [5:0] d,
                       input logic b, input logic g, input logic [19:0] exp_ph);
    load_new_note        = ld;
    note_to_load         = n;
    duration_to_load     = d;
    beat                 = b;
    generate_next_sample = g;
    if (g) sb_q.push_back(exp_ph);
    @(posedge clk);
    #1;
    load_new_note        = 1'b0;
    beat                 = 1'b0;
    generate_next_sample = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 20'd0);
  endtask

  // Monitor away from the active edge: scoreboard pop and note_done counting.
  always @(negedge clk) begin
    if (note_done === 1'b1) done_cnt++;
    if (sample_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got sample_valid=1 expected no pulse");
      end else begin
        check("sb_phase", phase, sb_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [5:0]  note;
    logic [5:0]  dur;
    int          nstr;
    logic [19:0] step;
    logic [19:0] final_ph;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          d0;
    int          bdone;
    logic [19:0] sum;

    vecs[0] = '{6'd49, 6'd3, 4,  20'd9612,  20'd38448};
    vecs[1] = '{6'd0,  6'd2, 3,  20'd0,     20'd0};
    vecs[2] = '{6'd63, 6'd4, 50, 20'd21578, 20'd30324};
    vecs[3] = '{6'd1,  6'd1, 5,  20'd601,   20'd3005};
    vecs[4] = '{6'd60, 6'd2, 2,  20'd18145, 20'd36290};
    vecs[5] = '{6'd37, 6'd5, 3,  20'd4806,  20'd14418};

    reset = 1'b1;
    play_enable = 1'b1;
    note_to_load = '0;
    duration_to_load = '0;
    load_new_note = 1'b0;
    beat = 1'b0;
    generate_next_sample = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", phase, 0);
    check("rst_playing", playing, 0);
    check("rst_note_done", note_done, 0);
    check("rst_sample_valid", sample_valid, 0);
    reset = 1'b0;
    idle();

    // Table: load, one early strobe (adds 0), strobes with beats, then expiry.
    foreach (vecs[k]) begin
      d0 = done_cnt;
      sum = '0;
      drive(1'b1, vecs[k].note, vecs[k].dur, 1'b0, 1'b0, 20'd0);
      check("vec_load_playing", playing, 1);
      check("vec_load_phase", phase, 0);
      drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 20'd0);
      bdone = 0;
      for (int i = 0; i < vecs[k].nstr; i++) begin
        sum = sum + vecs[k].step;
        if (i < int'(vecs[k].dur) - 1) begin
          drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, sum);
          bdone++;
        end else begin
          drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, sum);
        end
      end
      for (int j = bdone; j < int'(vecs[k].dur); j++) begin
        check("vec_no_early_done", done_cnt, d0);
        check("vec_still_playing", playing, 1);
        drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
      end
      check("vec_note_done", note_done, 1);
      check("vec_playing_fall", playing, 0);
      check("vec_final_phase", phase, vecs[k].final_ph);
      idle();
      check("vec_done_width", note_done, 0);
      check("vec_done_count", done_cnt, d0 + 1);
    end

    // Pause for 5 beats mid-note: counter and phase hold, strobes keep flowing.
    d0 = done_cnt;
    drive(1'b1, 6'd49, 6'd3, 1'b0, 1'b0, 20'd0);
    idle();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 20'd9612);
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
    play_enable = 1'b0;
    idle();
    check("pause_playing", playing, 1);
    repeat (5) drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 20'd9612);
    check("pause_no_done", done_cnt, d0);
    check("pause_phase_hold", phase, 9612);
    play_enable = 1'b1;
    idle();
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
    check("pause_beat2_no_done", note_done, 0);
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
    check("pause_done", note_done, 1);
    check("pause_playing_fall", playing, 0);
    idle();
    check("pause_done_count", done_cnt, d0 + 1);

    // Load coincident with the expiring beat: load wins, new duration counts.
    d0 = done_cnt;
    drive(1'b1, 6'd49, 6'd2, 1'b0, 1'b0, 20'd0);
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
    drive(1'b1, 6'd50, 6'd3, 1'b1, 1'b0, 20'd0);
    check("ldexp_no_done", note_done, 0);
    check("ldexp_playing", playing, 1);
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
    check("ldexp_no_early_done", done_cnt, d0);
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
    check("ldexp_done", note_done, 1);
    idle();
    check("ldexp_done_count", done_cnt, d0 + 1);

    // Zero-duration load: immediate note_done, no phase advance.
    d0 = done_cnt;
    drive(1'b1, 6'd49, 6'd0, 1'b0, 1'b1, 20'd0);
    check("dur0_done", note_done, 1);
    check("dur0_playing", playing, 0);
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 20'd0);
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 20'd0);
    check("dur0_phase", phase, 0);
    check("dur0_done_count", done_cnt, d0 + 1);

    // Reset on the first of four beats: note aborted without note_done.
    d0 = done_cnt;
    drive(1'b1, 6'd49, 6'd4, 1'b0, 1'b0, 20'd0);
    idle();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 20'd9612);
    reset = 1'b1;
    drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 20'd0);
    reset = 1'b0;
    check("rstmid_phase", phase, 0);
    check("rstmid_playing", playing, 0);
    check("rstmid_note_done", note_done, 0);
    check("rstmid_sample_valid", sample_valid, 0);
    repeat (5) drive(1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 20'd0);
    check("rstmid_no_done", done_cnt, d0);
    check("rstmid_idle", playing, 0);

    idle();
    idle();
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
